// File: rtl/reg_lock_seq_pkg.sv
// Shared types and constants for the register-lock sequencer.
//   seq_state_t    : sequencer FSM state encoding
//   PORT_A/B/D     : index of the source-A, source-B and destination port
//   NUM_SEQ_PORTS  : register-file ports driven by one sequencer
//   DATA_W         : register data width
package reg_lock_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACQUIRE,
    S_EXEC,
    S_WAIT_WB,
    S_RELEASE
  } seq_state_t;

  localparam int PORT_A        = 0;
  localparam int PORT_B        = 1;
  localparam int PORT_D        = 2;
  localparam int NUM_SEQ_PORTS = 3;
  localparam int DATA_W        = 32;

endpackage

// File: rtl/reg_lock_seq_grant_tracker.sv
// Per-port grant bookkeeping for one register-file port of the sequencer.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   clear        : new instruction accepted; forget everything
//   active       : sequencer is acquiring locks
//   used         : this port takes part in the current instruction
//   grant, rdata : grant and read data from the register file
//   done         : port needs nothing more (unused, already granted, or granted now)
//   data         : operand captured at the grant (read ports only)
//   early_pulse  : one-cycle early release, the cycle after capture
//   early_done   : early release already sent; lock no longer held
module reg_lock_seq_grant_tracker #(
  parameter int DATA_W     = 32,
  parameter bit CAPTURE_EN = 1'b1,
  parameter bit EARLY_EN   = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              active,
  input  logic              used,
  input  logic              grant,
  input  logic [DATA_W-1:0] rdata,
  output logic              done,
  output logic [DATA_W-1:0] data,
  output logic              early_pulse,
  output logic              early_done
);

  logic flag;
  logic set_now;

  // A grant seen after the flag is set is ignored, so a dropped grant cannot
  // disturb the captured operand.
  assign set_now = active && used && grant && !flag;
  assign done    = flag || set_now || !used;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag        <= 1'b0;
      data        <= '0;
      early_pulse <= 1'b0;
      early_done  <= 1'b0;
    end else if (clear) begin
      flag        <= 1'b0;
      data        <= '0;
      early_pulse <= 1'b0;
      early_done  <= 1'b0;
    end else begin
      if (set_now) flag <= 1'b1;
      if (set_now && CAPTURE_EN) data <= rdata;
      early_pulse <= set_now && CAPTURE_EN && EARLY_EN;
      if (early_pulse) early_done <= 1'b1;
    end
  end

endmodule

// File: rtl/reg_lock_sequencer.sv
// Per-issue-slot sequencer: locks the source/destination registers of one
// instruction, captures operands, hands them to execute, takes the writeback
// and commits it while releasing the locks.
// Optional feature: define REG_LOCK_SEQ_EARLY_READ_RELEASE_EN to release each
// read lock the cycle after its operand is captured instead of in RELEASE.
// Ports:
//   clk, rst                  : clock, asynchronous active-high reset
//   issue_*/use_*/*_addr      : instruction offer and handshake
//   flush                     : abandon the current instruction (no commit)
//   port_*                    : three register-file port bundles (0=A, 1=B, 2=D)
//   op_valid/op_ready/op_a/b  : operand handoff to execute
//   wb_valid/wb_ready/wb_data : result from execute
//   busy                      : sequencer not idle
module reg_lock_sequencer
  import reg_lock_seq_pkg::*;
#(
  parameter  int NUM_PHY_REGS = 32,
  parameter  int ID_WIDTH     = 8,
  localparam int AW           = $clog2(NUM_PHY_REGS)
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      issue_valid,
  output logic                                      issue_ready,
  input  logic [ID_WIDTH-1:0]                       issue_id,
  input  logic [AW-1:0]                             src_a_addr,
  input  logic [AW-1:0]                             src_b_addr,
  input  logic [AW-1:0]                             dst_addr,
  input  logic                                      use_a,
  input  logic                                      use_b,
  input  logic                                      use_dst,
  input  logic                                      flush,
  output logic [NUM_SEQ_PORTS-1:0][AW-1:0]          port_addr,
  output logic [NUM_SEQ_PORTS-1:0]                  port_req_read,
  output logic [NUM_SEQ_PORTS-1:0]                  port_req_write,
  output logic [NUM_SEQ_PORTS-1:0]                  port_release,
  output logic [NUM_SEQ_PORTS-1:0][ID_WIDTH-1:0]    port_issue_id,
  output logic [NUM_SEQ_PORTS-1:0][DATA_W-1:0]      port_wdata,
  input  logic [NUM_SEQ_PORTS-1:0][DATA_W-1:0]      port_rdata,
  input  logic [NUM_SEQ_PORTS-1:0]                  port_grant,
  output logic                                      op_valid,
  input  logic                                      op_ready,
  output logic [DATA_W-1:0]                         op_a,
  output logic [DATA_W-1:0]                         op_b,
  input  logic                                      wb_valid,
  output logic                                      wb_ready,
  input  logic [DATA_W-1:0]                         wb_data,
  output logic                                      busy
);

`ifdef REG_LOCK_SEQ_EARLY_READ_RELEASE_EN
  localparam bit EARLY_RD_REL = 1'b1;
`else
  localparam bit EARLY_RD_REL = 1'b0;
`endif

  seq_state_t                         state, state_nxt;
  logic [NUM_SEQ_PORTS-1:0]           use_q;
  logic [NUM_SEQ_PORTS-1:0][AW-1:0]   addr_q;
  logic [ID_WIDTH-1:0]                id_q;
  logic [DATA_W-1:0]                  wdata_q;
  logic                               commit_q;
  logic                               accept;
  logic                               acquiring;
  logic [NUM_SEQ_PORTS-1:0]           done;
  logic [NUM_SEQ_PORTS-1:0]           early_pulse;
  logic [NUM_SEQ_PORTS-1:0]           early_done;
  logic [DATA_W-1:0]                  cap_data [NUM_SEQ_PORTS];
  logic                               unused_dst_data;

  assign issue_ready = (state == S_IDLE);
  assign accept      = issue_valid && issue_ready;
  assign acquiring   = (state == S_ACQUIRE);

  for (genvar i = 0; i < NUM_SEQ_PORTS; i++) begin : g_trk
    reg_lock_seq_grant_tracker #(
      .DATA_W    (DATA_W),
      .CAPTURE_EN(i != PORT_D),
      .EARLY_EN  (EARLY_RD_REL && (i != PORT_D))
    ) u_trk (
      .clk        (clk),
      .rst        (rst),
      .clear      (accept),
      .active     (acquiring),
      .used       (use_q[i]),
      .grant      (port_grant[i]),
      .rdata      (port_rdata[i]),
      .done       (done[i]),
      .data       (cap_data[i]),
      .early_pulse(early_pulse[i]),
      .early_done (early_done[i])
    );
  end

  assign op_a            = cap_data[PORT_A];
  assign op_b            = cap_data[PORT_B];
  assign unused_dst_data = ^cap_data[PORT_D];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // commit_q marks that a real result was taken; a flushed instruction
  // reaches RELEASE without it, which suppresses the commit write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      use_q    <= '0;
      addr_q   <= '0;
      id_q     <= '0;
      wdata_q  <= '0;
      commit_q <= 1'b0;
    end else begin
      if (accept) begin
        use_q            <= {use_dst, use_b, use_a};
        addr_q[PORT_A]   <= src_a_addr;
        addr_q[PORT_B]   <= src_b_addr;
        addr_q[PORT_D]   <= dst_addr;
        id_q             <= issue_id;
        commit_q         <= 1'b0;
      end
      if (state == S_WAIT_WB && wb_valid) begin
        wdata_q  <= wb_data;
        commit_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (accept) state_nxt = S_ACQUIRE;
      S_ACQUIRE: begin
        if (flush)      state_nxt = S_RELEASE;
        else if (&done) state_nxt = S_EXEC;
      end
      S_EXEC: begin
        if (flush)         state_nxt = S_RELEASE;
        else if (op_ready) state_nxt = use_q[PORT_D] ? S_WAIT_WB : S_RELEASE;
      end
      S_WAIT_WB: if (wb_valid) state_nxt = S_RELEASE;
      S_RELEASE: state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    port_addr      = addr_q;
    port_req_read  = '0;
    port_req_write = '0;
    port_release   = '0;
    port_issue_id  = '0;
    port_wdata     = '0;
    for (int i = 0; i < NUM_SEQ_PORTS; i++) begin
      port_issue_id[i] = id_q;
      port_req_read[i] = (i != PORT_D) && (state != S_IDLE) && use_q[i] && !early_done[i];
      port_release[i]  = early_pulse[i] ||
                         ((state == S_RELEASE) && use_q[i] && !early_done[i]);
    end
    port_req_write[PORT_D] = (state != S_IDLE) && use_q[PORT_D] &&
                             ((state != S_RELEASE) || commit_q);
    if (state == S_RELEASE && commit_q) port_wdata[PORT_D] = wdata_q;
  end

  assign op_valid = (state == S_EXEC);
  assign wb_ready = (state == S_WAIT_WB);
  assign busy     = (state != S_IDLE);

endmodule

// File: doc/reg_lock_sequencer.md
Name: reg_lock_sequencer

Overview:
- Per-slot controller that takes one issued instruction and drives its three register-file access ports: source A read, source B read, destination write.
- Acquires locks on those registers and captures operands.
- Hands operands to execute, accepts the writeback, then commits and releases the locks.
- One instance per issue slot; its 3 port bundles connect to 3 of the register file's TOTAL_PORTS ports.

Parameters:
- NUM_PHY_REGS, 32, number of physical registers; address width AW = $clog2(NUM_PHY_REGS).
- ID_WIDTH, 8, issue-ID width; passed unchanged to the register file.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- issue_valid  in  1  instruction offered
- issue_ready  out  1  sequencer idle and can accept
- issue_id  in  ID_WIDTH  issue sequence number
- src_a_addr / src_b_addr / dst_addr  in  AW each  register addresses
- use_a / use_b / use_dst  in  1 each  per-port enable
- flush  in  1  abandon current instruction
- port_addr  out  AW[3]  to register file; index 0=A, 1=B, 2=D
- port_req_read / port_req_write / port_release  out  1[3]  to register file
- port_issue_id  out  ID_WIDTH[3]  to register file
- port_wdata  out  32[3]  to register file
- port_rdata  in  32[3]  from register file
- port_grant  in  1[3]  from register file
- op_valid  out  1  operands valid to execute
- op_ready  in  1  execute accepts operands
- op_a / op_b  out  32 each  captured operands; 0 when port unused
- wb_valid  in  1  result offered
- wb_ready  out  1  sequencer accepts result
- wb_data  in  32  result
- busy  out  1  state != IDLE

Behaviour:
- States: IDLE, ACQUIRE, EXEC, WAIT_WB, RELEASE.
- Reset (asynchronous, rst=1): state=IDLE; all port_req_*, port_release, op_valid and wb_ready =0; op_a/op_b/port_wdata =0; grant flags cleared. Locks are not explicitly released; the register file is reset on the same rst.
- IDLE:
  - issue_ready=1.
  - On issue_valid && issue_ready: latch addresses, use_* and issue_id; clear grant flags; go to ACQUIRE on the next cycle.
  - issue_ready=0 in every other state.
- ACQUIRE:
  - port_addr, port_issue_id and req are driven from latched values: req_read[0]=use_a, req_read[1]=use_b, req_write[2]=use_dst.
  - Requests are held continuously until release.
  - Each cycle a used port has port_grant=1 and its flag is clear: set the flag; read ports capture port_rdata into op_a/op_b in that same edge.
  - When all used ports' flags are set, go to EXEC (earliest: the cycle after the last grant).
  - With no ports used, go to EXEC after 1 cycle.
- EXEC:
  - op_valid=1; op_a/op_b stable.
  - On op_ready: go to WAIT_WB if use_dst, else go to RELEASE.
- WAIT_WB:
  - wb_ready=1.
  - On wb_valid: latch wb_data into a wdata register; go to RELEASE.
- RELEASE (exactly 1 cycle):
  - port_release=1 on every used port still held.
  - Port 2 drives req_write=1 and port_wdata = latched result; the register file commits on release.
  - All req drop the next cycle; go to IDLE.
- flush:
  - Flush in ACQUIRE or EXEC goes to RELEASE with req_write[2] forced to 0, so there is no commit; locks are still released.
  - Flush in WAIT_WB is ignored; the commit proceeds.
  - Flush in IDLE or RELEASE has no effect.
  - Flush wins over a simultaneous op_ready.
- Same-register conflicts (A==B, or A==D): no special handling; each port waits on its own grant, and the register file orders by issue_id.
- A grant is never rescinded while a request is held; a drop of port_grant after its flag is set is ignored.
- port_wdata[0], port_wdata[1] =0; port_wdata[2] =0 outside RELEASE.

Optional Feature:
- Macro: REG_LOCK_SEQ_EARLY_READ_RELEASE_EN.
- Defined:
  - Each read port pulses port_release=1 for one cycle in the cycle after its data is captured.
  - From the following cycle it drops req_read, and is excluded from the RELEASE-state release.
  - Other instructions' writers to that register are unblocked earlier.
- Undefined: read locks are held until the RELEASE state.

Decomposition:
- Package reg_lock_seq_pkg:
  - state enum type;
  - port index constants PORT_A=0, PORT_B=1, PORT_D=2;
  - NUM_SEQ_PORTS=3.
- Sub-module reg_lock_seq_grant_tracker, instantiated 3×: holds the grant flag, the captured data and the early-release pulse per port.

Test Plan:
- Reset mid-ACQUIRE (rst high 2 cycles) -> all outputs 0, busy=0, issue_ready=1 on the first cycle after rst falls.
- A=3, B=5, D=7, all grants in the cycle after issue, rdata 0x11/0x22 -> op_a=0x11, op_b=0x22, op_valid 2 cycles after issue. Then wb_data=0xDEAD -> RELEASE pulse on all 3 ports, port_wdata[2]=0xDEAD, back to IDLE.
- Grant for B delayed 5 cycles (A, D immediate) -> op_valid rises exactly 1 cycle after B's grant; op_a keeps the value captured at A's grant.
- use_dst=0, use_b=0 -> no WAIT_WB; RELEASE only on port 0, one cycle after op handshake.
- Flush in EXEC -> RELEASE with port_release on all used ports, req_write[2]=0, no commit.
- With macro defined: release[0] and release[1] pulse 1 cycle after capture; in RELEASE only release[2]=1.
